// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer between the LSU and the 64-bit BIU: lane alignment,
// byte selects, two-beat splitting of 8-byte-crossing accesses and load merge.
module lsu_misalign_seq #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_unsign,
    input  logic [3:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          biu_valid,
    input  logic          biu_ready,
    output logic          biu_write,
    output logic [AW-1:0] biu_addr,
    output logic [7:0]    biu_bsel,
    output logic [DW-1:0] biu_wdata,
    input  logic          biu_rvalid,
    input  logic [DW-1:0] biu_rdata,
    input  logic          biu_err
);

    typedef enum logic [2:0] {IDLE, B0, W0, B1, W1, RESP} state_e;

    state_e        state_q;
    logic          write_q, unsign_q, split_q, err_q;
    logic [3:0]    size_q;
    logic [2:0]    off_q;
    logic [DW-1:0] wdata_q, rdata0_q;

    logic          req_ready_q, rsp_valid_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          biu_valid_q, biu_write_q;
    logic [AW-1:0] biu_addr_q;
    logic [7:0]    biu_bsel_q;
    logic [DW-1:0] biu_wdata_q;

    function automatic logic is_onehot4(input logic [3:0] s);
        return (s != 4'b0) && ((s & (s - 4'd1)) == 4'b0);
    endfunction

    function automatic logic [3:0] size_bytes(input logic [3:0] s);
        case (s)
            4'b0001: return 4'd1;
            4'b0010: return 4'd2;
            4'b0100: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [3:0] s);
        case (s)
            4'b0001: return 8'h01;
            4'b0010: return 8'h03;
            4'b0100: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Lane shifts over a 16-byte window: low half is beat 0, high half beat 1.
    logic [3:0]      sz_sel;
    logic [2:0]      off_sel;
    logic [DW-1:0]   wd_sel;
    logic [15:0]     bsel_d;
    logic [2*DW-1:0] lanes_d;
    logic            split_d;

    assign sz_sel  = (state_q == IDLE) ? req_size      : size_q;
    assign off_sel = (state_q == IDLE) ? req_addr[2:0] : off_q;
    assign wd_sel  = (state_q == IDLE) ? req_wdata     : wdata_q;
    assign bsel_d  = {8'h00, size_mask(sz_sel)} << off_sel;
    assign lanes_d = {{DW{1'b0}}, wd_sel} << {off_sel, 3'b000};
    assign split_d = ({1'b0, req_addr[2:0]} + size_bytes(req_size)) > 4'd8;

    // In W0 the upper beat is absent (zero); in W1 beat 0 comes from rdata0_q.
    logic [DW-1:0] ld_t, ld_ext;
    assign ld_t = DW'(((state_q == W1) ? {biu_rdata, rdata0_q}
                                       : {{DW{1'b0}}, biu_rdata}) >> {off_q, 3'b000});

    always_comb begin
        ld_ext = ld_t;
        case (size_q)
            4'b0001: ld_ext = {{(DW-8){~unsign_q & ld_t[7]}},   ld_t[7:0]};
            4'b0010: ld_ext = {{(DW-16){~unsign_q & ld_t[15]}}, ld_t[15:0]};
            4'b0100: ld_ext = {{(DW-32){~unsign_q & ld_t[31]}}, ld_t[31:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            unsign_q    <= 1'b0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 4'b0;
            off_q       <= 3'b0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            biu_valid_q <= 1'b0;
            biu_write_q <= 1'b0;
            biu_addr_q  <= '0;
            biu_bsel_q  <= 8'h00;
            biu_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    write_q     <= req_write;
                    unsign_q    <= req_unsign;
                    size_q      <= req_size;
                    off_q       <= req_addr[2:0];
                    wdata_q     <= req_wdata;
                    split_q     <= split_d;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b0;
                    if (!is_onehot4(req_size)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q     <= B0;
                        biu_valid_q <= 1'b1;
                        biu_write_q <= req_write;
                        biu_addr_q  <= {req_addr[AW-1:3], 3'b000};
                        biu_bsel_q  <= bsel_d[7:0];
                        biu_wdata_q <= lanes_d[DW-1:0];
                    end
                end
                B0: if (biu_ready) begin
                    biu_valid_q <= 1'b0;
                    state_q     <= W0;
                end
                W0: if (biu_rvalid) begin
                    rdata0_q <= biu_rdata;
                    err_q    <= biu_err;
                    if (biu_err || !split_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= biu_err;
                        rsp_rdata_q <= (biu_err || write_q) ? '0 : ld_ext;
                    end else begin
                        state_q     <= B1;
                        biu_valid_q <= 1'b1;
                        biu_addr_q  <= biu_addr_q + AW'(8);
                        biu_bsel_q  <= bsel_d[15:8];
                        biu_wdata_q <= lanes_d[2*DW-1:DW];
                    end
                end
                B1: if (biu_ready) begin
                    biu_valid_q <= 1'b0;
                    state_q     <= W1;
                end
                W1: if (biu_rvalid) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q | biu_err;
                    rsp_rdata_q <= (err_q || biu_err || write_q) ? '0 : ld_ext;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign biu_valid = biu_valid_q;
    assign biu_write = biu_write_q;
    assign biu_addr  = biu_addr_q;
    assign biu_bsel  = biu_bsel_q;
    assign biu_wdata = biu_wdata_q;

endmodule
